// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side signals of the round-robin bus host arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface bus_host_arbiter_if #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
);
    logic [NrHosts-1:0]              host_req_i;
    logic [NrHosts-1:0]              host_gnt_o;
    logic [NrHosts*AddressWidth-1:0] host_addr_i;
    logic [NrHosts-1:0]              host_we_i;
    logic [NrHosts*4-1:0]            host_be_i;
    logic [NrHosts*DataWidth-1:0]    host_wdata_i;
    logic [NrHosts-1:0]              host_rvalid_o;
    logic [DataWidth-1:0]            host_rdata_o;
    logic [NrHosts-1:0]              host_err_o;

    logic                            dev_req_o;
    logic                            dev_gnt_i;
    logic [AddressWidth-1:0]         dev_addr_o;
    logic                            dev_we_o;
    logic [3:0]                      dev_be_o;
    logic [DataWidth-1:0]            dev_wdata_o;
    logic                            dev_rvalid_i;
    logic [DataWidth-1:0]            dev_rdata_i;
    logic                            dev_err_i;

    logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o;
    logic                                unexpected_rvalid_o;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        output outstanding_o, unexpected_rvalid_o
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        input  outstanding_o, unexpected_rvalid_o
    );
endinterface

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid bus host port among NrHosts requesters.
// Zero-cycle request path; selection locks while the device stalls; tag FIFO routes in-order responses.
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    bus_host_arbiter_if.slave   bus
);
    localparam int PW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int TW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);

    logic [PW-1:0]      r_prio_ptr;
    logic [PW-1:0]      r_lock_idx;
    logic               r_locked;
    logic [PW-1:0]      r_tag [MaxOutstanding];
    logic [TW-1:0]      r_wptr;
    logic [TW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic [PW-1:0]      w_sel;
    logic [PW-1:0]      w_head;
    logic               w_full;
    logic               w_dev_req;
    logic               w_grant;
    logic               w_pop;
    logic [NrHosts-1:0] w_gnt;
    logic [NrHosts-1:0] w_rvalid;
    logic [NrHosts-1:0] w_err;

    // Scan downward so the closest requester above prio_ptr is the last one written.
    always_comb begin
        int idx;
        w_sel = r_prio_ptr;
        for (int k = NrHosts - 1; k >= 0; k--) begin
            idx = int'(r_prio_ptr) + k;
            if (idx >= NrHosts) idx = idx - NrHosts;
            if (bus.host_req_i[idx]) w_sel = PW'(idx);
        end
        if (r_locked) w_sel = r_lock_idx;
    end

    assign w_full    = (r_count == CW'(MaxOutstanding));
    assign w_dev_req = (r_locked | (|bus.host_req_i)) & ~w_full & ~rst_i;
    assign w_grant   = w_dev_req & bus.dev_gnt_i;
    assign w_pop     = bus.dev_rvalid_i & (r_count != '0) & ~rst_i;
    assign w_head    = r_tag[r_rptr];

    always_comb begin
        w_gnt    = '0;
        w_rvalid = '0;
        w_err    = '0;
        if (w_grant) w_gnt[w_sel] = 1'b1;
        if (w_pop) begin
            w_rvalid[w_head] = 1'b1;
            w_err[w_head]    = bus.dev_err_i;
        end
    end

    assign bus.host_gnt_o          = w_gnt;
    assign bus.host_rvalid_o       = w_rvalid;
    assign bus.host_err_o          = w_err;
    assign bus.host_rdata_o        = bus.dev_rdata_i;
    assign bus.dev_req_o           = w_dev_req;
    assign bus.dev_addr_o          = bus.host_addr_i[w_sel*AddressWidth +: AddressWidth];
    assign bus.dev_we_o            = bus.host_we_i[w_sel];
    assign bus.dev_be_o            = bus.host_be_i[w_sel*4 +: 4];
    assign bus.dev_wdata_o         = bus.host_wdata_i[w_sel*DataWidth +: DataWidth];
    assign bus.outstanding_o       = r_count;
    assign bus.unexpected_rvalid_o = bus.dev_rvalid_i & (r_count == '0) & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio_ptr <= '0;
            r_lock_idx <= '0;
            r_locked   <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_grant) begin
                r_tag[r_wptr] <= w_sel;
                r_wptr        <= (r_wptr == TW'(MaxOutstanding - 1)) ? '0 : r_wptr + 1'b1;
                r_prio_ptr    <= (w_sel == PW'(NrHosts - 1)) ? '0 : w_sel + 1'b1;
                r_locked      <= 1'b0;
            end else if (w_dev_req) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_sel;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == TW'(MaxOutstanding - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed vector table plus a randomized two-host stall/response sequence
// checked against a grant-order scoreboard and a fairness bound.
module tb_bus_host_arbiter;
    localparam int NH = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bus_host_arbiter_if #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)) bus ();

    bus_host_arbiter #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic        e_req;
        logic [1:0]  e_rv;
        logic [1:0]  e_err;
        logic [1:0]  e_out;
        logic        e_unx;
        int          e_sel;
    } vec_t;

    vec_t vecs[24];

    logic [31:0] haddr [NH];
    logic [31:0] hwdata[NH];
    logic [3:0]  hbe   [NH];
    logic        hwe   [NH];

    function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic g, input logic v,
                                input logic e, input logic [31:0] d, input logic [1:0] eg,
                                input logic erq, input logic [1:0] ev, input logic [1:0] ee,
                                input logic [1:0] eo, input logic eu, input int es);
        vec_t t;
        t.rst = r; t.req = rq; t.gnt = g; t.rv = v; t.err = e; t.rdata = d;
        t.e_gnt = eg; t.e_req = erq; t.e_rv = ev; t.e_err = ee; t.e_out = eo;
        t.e_unx = eu; t.e_sel = es;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    initial begin
        int q[$];
        int since[NH];
        logic        g, v, exp_req;
        logic [1:0]  exp_rv;
        logic [31:0] d;
        int          gid;

        n_checks = 0;
        n_errors = 0;
        for (int h = 0; h < NH; h++) begin
            haddr[h]  = 32'h0010_0004 * (h + 1);
            hwdata[h] = 32'h1111_0000 + h;
            hbe[h]    = (h == 0) ? 4'h3 : 4'hC;
            hwe[h]    = (h == 1);
        end
        for (int h = 0; h < NH; h++) begin
            bus.host_addr_i[h*AW +: AW]  = haddr[h];
            bus.host_wdata_i[h*DW +: DW] = hwdata[h];
            bus.host_be_i[h*4 +: 4]      = hbe[h];
            bus.host_we_i[h]             = hwe[h];
        end
        rst = 1'b1;
        bus.host_req_i   = '0;
        bus.dev_gnt_i    = 1'b0;
        bus.dev_rvalid_i = 1'b0;
        bus.dev_rdata_i  = '0;
        bus.dev_err_i    = 1'b0;

        //              rst req  gnt rv err rdata          egnt  ereq erv   eerr  eout unx sel
        vecs[0]  = mk(0, 2'b01, 1, 0, 0, 32'h0,        2'b01, 1, 2'b00, 2'b00, 2'd0, 0, 0);
        vecs[1]  = mk(0, 2'b00, 1, 1, 0, 32'hDEADBEEF, 2'b00, 0, 2'b01, 2'b00, 2'd1, 0, 0);
        vecs[2]  = mk(1, 2'b00, 0, 0, 0, 32'h0,        2'b00, 0, 2'b00, 2'b00, 2'd0, 0, 0);
        vecs[3]  = mk(0, 2'b11, 1, 0, 0, 32'h0,        2'b01, 1, 2'b00, 2'b00, 2'd0, 0, 0);
        vecs[4]  = mk(0, 2'b11, 1, 1, 0, 32'hA1A1A1A1, 2'b10, 1, 2'b01, 2'b00, 2'd1, 0, 1);
        vecs[5]  = mk(0, 2'b11, 1, 1, 0, 32'hA2A2A2A2, 2'b01, 1, 2'b10, 2'b00, 2'd1, 0, 0);
        vecs[6]  = mk(0, 2'b11, 1, 1, 0, 32'hA3A3A3A3, 2'b10, 1, 2'b01, 2'b00, 2'd1, 0, 1);
        vecs[7]  = mk(0, 2'b00, 1, 1, 0, 32'hA4A4A4A4, 2'b00, 0, 2'b10, 2'b00, 2'd1, 0, 0);
        vecs[8]  = mk(0, 2'b10, 0, 0, 0, 32'h0,        2'b00, 1, 2'b00, 2'b00, 2'd0, 0, 1);
        vecs[9]  = mk(0, 2'b11, 0, 0, 0, 32'h0,        2'b00, 1, 2'b00, 2'b00, 2'd0, 0, 1);
        vecs[10] = mk(0, 2'b11, 0, 0, 0, 32'h0,        2'b00, 1, 2'b00, 2'b00, 2'd0, 0, 1);
        vecs[11] = mk(0, 2'b11, 1, 0, 0, 32'h0,        2'b10, 1, 2'b00, 2'b00, 2'd0, 0, 1);
        vecs[12] = mk(0, 2'b01, 1, 0, 0, 32'h0,        2'b01, 1, 2'b00, 2'b00, 2'd1, 0, 0);
        vecs[13] = mk(0, 2'b10, 1, 0, 0, 32'h0,        2'b00, 0, 2'b00, 2'b00, 2'd2, 0, 1);
        vecs[14] = mk(0, 2'b10, 1, 1, 0, 32'hB1B1B1B1, 2'b00, 0, 2'b10, 2'b00, 2'd2, 0, 1);
        vecs[15] = mk(0, 2'b10, 1, 1, 0, 32'hB2B2B2B2, 2'b10, 1, 2'b01, 2'b00, 2'd1, 0, 1);
        vecs[16] = mk(0, 2'b00, 0, 1, 1, 32'hB3B3B3B3, 2'b00, 0, 2'b10, 2'b10, 2'd1, 0, 0);
        vecs[17] = mk(0, 2'b00, 0, 1, 0, 32'h0,        2'b00, 0, 2'b00, 2'b00, 2'd0, 1, 0);
        vecs[18] = mk(0, 2'b00, 0, 0, 0, 32'h0,        2'b00, 0, 2'b00, 2'b00, 2'd0, 0, 0);
        vecs[19] = mk(0, 2'b11, 1, 0, 0, 32'h0,        2'b01, 1, 2'b00, 2'b00, 2'd0, 0, 0);
        vecs[20] = mk(0, 2'b11, 1, 0, 0, 32'h0,        2'b10, 1, 2'b00, 2'b00, 2'd1, 0, 1);
        vecs[21] = mk(1, 2'b11, 1, 1, 1, 32'hC1C1C1C1, 2'b00, 0, 2'b00, 2'b00, 2'd2, 0, 0);
        vecs[22] = mk(1, 2'b11, 0, 0, 0, 32'h0,        2'b00, 0, 2'b00, 2'b00, 2'd0, 0, 0);
        vecs[23] = mk(0, 2'b00, 0, 1, 0, 32'hC2C2C2C2, 2'b00, 0, 2'b00, 2'b00, 2'd0, 1, 0);

        repeat (3) @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #2;
            rst              = vecs[i].rst;
            bus.host_req_i   = vecs[i].req;
            bus.dev_gnt_i    = vecs[i].gnt;
            bus.dev_rvalid_i = vecs[i].rv;
            bus.dev_err_i    = vecs[i].err;
            bus.dev_rdata_i  = vecs[i].rdata;
            #2;
            chk("host_gnt",    i, 64'(bus.host_gnt_o),          64'(vecs[i].e_gnt));
            chk("dev_req",     i, 64'(bus.dev_req_o),           64'(vecs[i].e_req));
            chk("host_rvalid", i, 64'(bus.host_rvalid_o),       64'(vecs[i].e_rv));
            chk("host_err",    i, 64'(bus.host_err_o),          64'(vecs[i].e_err));
            chk("outstanding", i, 64'(bus.outstanding_o),       64'(vecs[i].e_out));
            chk("unexpected",  i, 64'(bus.unexpected_rvalid_o), 64'(vecs[i].e_unx));
            chk("host_rdata",  i, 64'(bus.host_rdata_o),        64'(vecs[i].rdata));
            if (vecs[i].e_req) begin
                chk("dev_addr",  i, 64'(bus.dev_addr_o),  64'(haddr[vecs[i].e_sel]));
                chk("dev_wdata", i, 64'(bus.dev_wdata_o), 64'(hwdata[vecs[i].e_sel]));
                chk("dev_be",    i, 64'(bus.dev_be_o),    64'(hbe[vecs[i].e_sel]));
                chk("dev_we",    i, 64'(bus.dev_we_o),    64'(hwe[vecs[i].e_sel]));
            end
        end

        // Both hosts requesting continuously with random stalls and responses.
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.host_req_i   = '0;
        bus.dev_rvalid_i = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int h = 0; h < NH; h++) since[h] = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #2;
            g = 1'($urandom_range(0, 1));
            v = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            d = $urandom;
            bus.host_req_i   = 2'b11;
            bus.dev_gnt_i    = g;
            bus.dev_rvalid_i = v;
            bus.dev_rdata_i  = d;
            bus.dev_err_i    = 1'b0;
            #2;
            exp_req = (q.size() < MO);
            exp_rv  = v ? (2'b01 << q[0]) : 2'b00;
            chk("rr_dev_req", c, 64'(bus.dev_req_o),     64'(exp_req));
            chk("rr_rvalid",  c, 64'(bus.host_rvalid_o), 64'(exp_rv));
            chk("rr_rdata",   c, 64'(bus.host_rdata_o),  64'(d));
            chk("rr_gnt_any", c, 64'(|bus.host_gnt_o),   64'(g & exp_req));
            chk("rr_onehot",  c, 64'($onehot0(bus.host_gnt_o)), 64'(1));
            if (v) void'(q.pop_front());
            if (bus.host_gnt_o != '0) begin
                gid = bus.host_gnt_o[1] ? 1 : 0;
                q.push_back(gid);
                for (int h = 0; h < NH; h++) begin
                    if (h == gid) begin
                        since[h] = 0;
                    end else begin
                        since[h]++;
                        n_checks++;
                        if (since[h] >= NH) begin
                            n_errors++;
                            $display("FAIL rr_fair [%0d]: host %0d skipped %0d grants, allowed %0d", c, h, since[h], NH - 1);
                        end
                    end
                end
            end
        end

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Round-robin arbiter that shares one host port of the system bus (req/gnt/rvalid protocol, in-order responses) between NrHosts requesters, e.g. the core data port and a DMA engine.
- Sits between the requesters and the `bus` host slot.
- Keeps the request stable while the downstream stalls.
- Records the issuing host of each granted transaction in a tag FIFO, so each response returns to the correct requester.

Parameters:
- NrHosts, 2, number of requesters (2..8).
- DataWidth, 32, data width.
- AddressWidth, 32, address width.
- MaxOutstanding, 2, maximum granted-but-unanswered transactions; tag FIFO depth (1..8).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- host_req_i  in  NrHosts  per-host request.
- host_gnt_o  out  NrHosts  per-host grant.
- host_addr_i  in  NrHosts*AddressWidth  host i address at slice i.
- host_we_i  in  NrHosts  write enable.
- host_be_i  in  NrHosts*4  byte enables.
- host_wdata_i  in  NrHosts*DataWidth  write data.
- host_rvalid_o  out  NrHosts  per-host response valid.
- host_rdata_o  out  DataWidth  response data, broadcast to all hosts.
- host_err_o  out  NrHosts  per-host error, qualified by host_rvalid_o.
- dev_req_o  out  1  downstream request.
- dev_gnt_i  in  1  downstream grant.
- dev_addr_o  out  AddressWidth  forwarded address.
- dev_we_o  out  1  forwarded write enable.
- dev_be_o  out  4  forwarded byte enables.
- dev_wdata_o  out  DataWidth  forwarded write data.
- dev_rvalid_i  in  1  downstream response valid.
- dev_rdata_i  in  DataWidth  downstream response data.
- dev_err_i  in  1  downstream response error.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current tag FIFO occupancy.
- unexpected_rvalid_o  out  1  one-cycle pulse when dev_rvalid_i arrives with the FIFO empty.

Behaviour:
- Reset (rst_i high at a clock edge): prio_ptr=0, locked=0, FIFO pointers and count=0.
  - While rst_i is high, all of host_gnt_o, host_rvalid_o, host_err_o, dev_req_o and unexpected_rvalid_o are 0.
  - Transactions outstanding at reset are discarded; responses arriving after reset raise unexpected_rvalid_o.
- Selection (combinational):
  - If locked, sel = lock_idx.
  - Otherwise sel = the first i with host_req_i[i]=1, scanning from prio_ptr upward with wrap-around modulo NrHosts.
- Full and request:
  - full = (count == MaxOutstanding).
  - dev_req_o = (locked | any host_req_i) & ~full.
  - There is no bypass: a pop in the same cycle does not unblock a full FIFO.
- Forwarding: dev_addr/we/be/wdata = host sel's slice. Zero-cycle latency from host_req_i to dev_req_o.
- Grant: host_gnt_o[sel] = dev_req_o & dev_gnt_i; all other bits are 0.
- On grant (clock edge):
  - Push sel into the tag FIFO.
  - prio_ptr <= (sel+1) mod NrHosts.
  - locked <= 0.
- Lock: if dev_req_o=1 and dev_gnt_i=0, then locked <= 1 and lock_idx <= sel.
  - The selection and forwarded fields stay stable until the grant, even if a higher-priority host raises its request.
  - Hosts hold their request until granted (bus protocol); the arbiter does not check this.
- Response: when dev_rvalid_i=1 and count>0:
  - Pop the FIFO head h.
  - host_rvalid_o[h]=1 and host_err_o[h]=dev_err_i, combinational in the same cycle.
  - host_rdata_o = dev_rdata_i at all times.
- Response with empty FIFO: when dev_rvalid_i=1 and count=0:
  - No host_rvalid_o asserted.
  - unexpected_rvalid_o=1 for that cycle.
  - State unchanged.
- Count update:
  - Simultaneous push and pop: count unchanged.
  - FIFO pointers wrap modulo MaxOutstanding.
- Ordering: responses are returned strictly in grant order.
- Fairness: under continuous requests from all hosts, each host is granted at least once every NrHosts grants.

Test Plan:
- Single host: host0 requests addr 0x100004, dev_gnt_i=1 → host_gnt_o=01 in the same cycle. Next cycle, dev_rvalid_i=1 with rdata 0xDEADBEEF → host_rvalid_o=01, host_rdata_o=0xDEADBEEF, outstanding_o returns to 0.
- Both hosts requesting continuously, dev_gnt_i=1, responses one cycle later → grant sequence 0,1,0,1. Responses are routed 0,1,0,1 with the matching rdata.
- Downstream stall: host1 requests with dev_gnt_i=0 for 3 cycles while host0 asserts its request in cycle 2:
  - dev_addr_o stays at host1's address throughout.
  - host1 is granted in cycle 4.
  - host0 is granted next.
- Full: MaxOutstanding=2, two grants with no responses:
  - A third request sees dev_req_o=0.
  - A response arriving in the same cycle does not grant it.
  - The third request is granted the following cycle.
- Error routing and unexpected response:
  - dev_err_i=1 on the response to host1 → host_err_o=10.
  - dev_rvalid_i with the FIFO empty → unexpected_rvalid_o pulses for 1 cycle and no host_rvalid_o is asserted.
- Reset mid-operation: assert rst_i with 2 transactions outstanding:
  - All outputs are 0 while rst_i is high.
  - outstanding_o=0 after reset.
  - A subsequent stale dev_rvalid_i raises unexpected_rvalid_o.
